// File: rtl/ripple_carry_adder_subtractor_pkg.sv
// Shared definitions for the ripple-carry adder/subtractor.
// Contents:
//   OP_ADD / OP_SUB : encoding of the ctrl operation-select bit.
//   is_sub()        : decodes ctrl into "invert B and force carry-in".
package ripple_carry_adder_subtractor_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic logic is_sub(input logic op);
    return (op == OP_SUB) && (op != OP_ADD);
  endfunction

endpackage

// File: rtl/ripple_carry_adder_subtractor_if.sv
// Operand/result bundle of the ripple-carry adder/subtractor.
// Signals:
//   A, B  : operands (WIDTH bits), ctrl : 0 = add, 1 = subtract
//   S     : registered result, Cout : registered per-stage carries,
//   V     : registered signed overflow
// Modports:
//   master : drives operands, observes results (producer side)
//   slave  : receives operands, drives results (the arithmetic unit)
interface ripple_carry_adder_subtractor_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             ctrl;
  logic [WIDTH-1:0] S;
  logic [WIDTH-1:0] Cout;
  logic             V;

  modport master (
    output A, B, ctrl,
    input  S, Cout, V
  );

  modport slave (
    input  A, B, ctrl,
    output S, Cout, V
  );

endinterface

// File: rtl/ripple_carry_adder_subtractor_full_adder.sv
// One-bit full-adder cell used as a stage of the ripple chain.
// Ports:
//   a, b, cin : addend bits and incoming carry
//   sum       : a ^ b ^ cin
//   cout      : majority(a, b, cin)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/ripple_carry_adder_subtractor.sv
// Registered WIDTH-bit two's-complement adder/subtractor built from a ripple
// chain of full-adder cells, one-cycle latency, one operation per cycle.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, clears S, Cout and V
//   bus  : slave side of the operand/result bundle
//          (A, B, ctrl in; S, Cout, V out, all outputs registered)
module ripple_carry_adder_subtractor
  import ripple_carry_adder_subtractor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  ripple_carry_adder_subtractor_if.slave  bus
);

  logic             sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;
  logic             ovf;

  logic [WIDTH-1:0] s_p1;
  logic [WIDTH-1:0] cout_p1;
  logic             v_p1;

  // Stage 0: combinational ripple from the operands to the register D side.
  // Subtraction is A + ~B + 1: B is inverted and the chain carry-in is set.
  assign sub   = is_sub(bus.ctrl);
  assign b_eff = bus.B ^ {WIDTH{sub}};
  assign carry[0] = sub;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    full_adder u_fa (
      .a    (bus.A[i]),
      .b    (b_eff[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign ovf = carry[WIDTH] ^ carry[WIDTH-1];

  // Stage 1: output registers; reset discards whatever is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_p1    <= '0;
      cout_p1 <= '0;
      v_p1    <= 1'b0;
    end else begin
      s_p1    <= sum;
      cout_p1 <= carry[WIDTH:1];
      v_p1    <= ovf;
    end
  end

  assign bus.S    = s_p1;
  assign bus.Cout = cout_p1;
  assign bus.V    = v_p1;

endmodule

// File: tb/tb_ripple_carry_adder_subtractor.sv
module tb_ripple_carry_adder_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ripple_carry_adder_subtractor_if #(.WIDTH(4)) if4 ();
  ripple_carry_adder_subtractor_if #(.WIDTH(8)) if8 ();

  ripple_carry_adder_subtractor #(.WIDTH(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4)
  );

  ripple_carry_adder_subtractor #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       ctrl;
    logic [3:0] s;
    logic [3:0] cout;
    logic       v;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Present operands, let one rising edge capture them, sample 1 time unit later.
  task automatic step4(input logic [3:0] a, input logic [3:0] b, input logic c);
    if4.A    = a;
    if4.B    = b;
    if4.ctrl = c;
    @(posedge clk);
    #1;
  endtask

  // Arithmetic reference: result, per-stage carries from partial sums,
  // and signed overflow from the integer range of the true result.
  task automatic ref_model(input int w, input int a, input int b, input int c,
                           output int s, output int cv, output int v);
    int mask, half, bb, sa, sb, r, m;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    bb   = (c != 0) ? ((~b) & mask) : b;
    s    = (a + bb + c) & mask;
    cv   = 0;
    for (int i = 0; i < w; i++) begin
      m  = (1 << (i + 1)) - 1;
      cv = cv | ((((a & m) + (bb & m) + c) >> (i + 1)) << i);
    end
    sa = (a >= half) ? a - (1 << w) : a;
    sb = (b >= half) ? b - (1 << w) : b;
    r  = (c != 0) ? sa - sb : sa + sb;
    v  = (r < -half || r > half - 1) ? 1 : 0;
  endtask

  initial begin
    int es, ec, ev;

    tbl[0] = '{4'h1, 4'h0, 1'b0, 4'b0001, 4'b0000, 1'b0};
    tbl[1] = '{4'h2, 4'h4, 1'b0, 4'b0110, 4'b0000, 1'b0};
    tbl[2] = '{4'hB, 4'h6, 1'b0, 4'b0001, 4'b1110, 1'b0};
    tbl[3] = '{4'h5, 4'h3, 1'b0, 4'b1000, 4'b0111, 1'b1};
    tbl[4] = '{4'h1, 4'h0, 1'b1, 4'b0001, 4'b1111, 1'b0};
    tbl[5] = '{4'h2, 4'h4, 1'b1, 4'b1110, 4'b0011, 1'b0};
    tbl[6] = '{4'hB, 4'h6, 1'b1, 4'b0101, 4'b1011, 1'b1};
    tbl[7] = '{4'h5, 4'h3, 1'b1, 4'b0010, 4'b1101, 1'b0};

    if8.A = '0;
    if8.B = '0;
    if8.ctrl = 1'b0;

    // Reset held for two edges with live inputs.
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step4(4'hF, 4'hF, 1'b1);
      chk("reset_S", {28'd0, if4.S}, 32'd0);
      chk("reset_Cout", {28'd0, if4.Cout}, 32'd0);
      chk("reset_V", {31'd0, if4.V}, 32'd0);
    end
    rst = 1'b0;

    // Directed table.
    foreach (tbl[i]) begin
      step4(tbl[i].a, tbl[i].b, tbl[i].ctrl);
      chk($sformatf("vec%0d_S", i), {28'd0, if4.S}, {28'd0, tbl[i].s});
      chk($sformatf("vec%0d_Cout", i), {28'd0, if4.Cout}, {28'd0, tbl[i].cout});
      chk($sformatf("vec%0d_V", i), {31'd0, if4.V}, {31'd0, tbl[i].v});
    end

    // Mode toggling every cycle: each edge reflects only its own inputs.
    for (int k = 0; k < 6; k++) begin
      step4(4'h5, 4'h3, k[0]);
      chk($sformatf("toggle%0d_S", k), {28'd0, if4.S}, (k[0] ? 32'd2 : 32'd8));
      chk($sformatf("toggle%0d_V", k), {31'd0, if4.V}, (k[0] ? 32'd0 : 32'd1));
    end

    // Reset mid-stream discards the in-flight result; first result one edge after release.
    if4.A = 4'h7; if4.B = 4'h7; if4.ctrl = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_S", {28'd0, if4.S}, 32'd0);
    chk("midrst_Cout", {28'd0, if4.Cout}, 32'd0);
    chk("midrst_V", {31'd0, if4.V}, 32'd0);
    rst = 1'b0;
    step4(4'h7, 4'h7, 1'b0);
    chk("postrst_S", {28'd0, if4.S}, 32'hE);
    chk("postrst_Cout", {28'd0, if4.Cout}, 32'h7);
    chk("postrst_V", {31'd0, if4.V}, 32'd1);

    // Exhaustive WIDTH=4 sweep over (A, B, ctrl).
    for (int c = 0; c < 2; c++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          step4(a[3:0], b[3:0], c[0]);
          ref_model(4, a, b, c, es, ec, ev);
          if (if4.S !== es[3:0])
            chk($sformatf("ex_S a=%0d b=%0d c=%0d", a, b, c), {28'd0, if4.S}, es);
          else if (if4.Cout !== ec[3:0])
            chk($sformatf("ex_Cout a=%0d b=%0d c=%0d", a, b, c), {28'd0, if4.Cout}, ec);
          else
            chk($sformatf("ex_V a=%0d b=%0d c=%0d", a, b, c), {31'd0, if4.V}, ev);
        end
      end
    end

    // WIDTH=8 random stimulus.
    for (int k = 0; k < 300; k++) begin
      int a, b, c;
      a = $urandom_range(255);
      b = $urandom_range(255);
      c = $urandom_range(1);
      if8.A = a[7:0];
      if8.B = b[7:0];
      if8.ctrl = c[0];
      @(posedge clk);
      #1;
      ref_model(8, a, b, c, es, ec, ev);
      chk($sformatf("w8_S a=%0d b=%0d c=%0d", a, b, c), {24'd0, if8.S}, es);
      chk($sformatf("w8_Cout a=%0d b=%0d c=%0d", a, b, c), {24'd0, if8.Cout}, ec);
      chk($sformatf("w8_V a=%0d b=%0d c=%0d", a, b, c), {31'd0, if8.V}, ev);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
